pipeline_control: RTL

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control_if.sv | 33 +++
 rtl/pipeline_control.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipeline_control_if.sv
// Decode/memory-stage handshake bundle between the pipeline datapath and
// pipeline_control. The master side is the datapath (drives decode and
// memory-stage status); the slave side is the controller.
interface pipeline_control_if;
    logic       id_valid;
    logic [4:0] id_rs1_idx;
    logic [4:0] id_rs2_idx;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd_idx;
    logic       id_reg_write;
    logic       mem_access;
    logic       dmem_ack;
    logic       jump_taken;
    logic       stall;
    logic       stall_front;
    logic       bubble_exec;
    logic       flush_front;
    logic       pc_redirect;
    logic [1:0] state_out;

    modport master (
        output id_valid, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
               id_rd_idx, id_reg_write, mem_access, dmem_ack, jump_taken,
        input  stall, stall_front, bubble_exec, flush_front, pc_redirect, state_out
    );

    modport slave (
        input  id_valid, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
               id_rd_idx, id_reg_write, mem_access, dmem_ack, jump_taken,
        output stall, stall_front, bubble_exec, flush_front, pc_redirect, state_out
    );
endinterface

// File: rtl/pipeline_control.sv
// Pipeline hazard / stall / flush controller.
// Tracks pending register writes in a three-slot shadow pipeline (EX, MEM,
// WB), stalls on memory waits, flushes the front end on taken jumps and
// inserts bubbles on read-after-write hazards. All state moves on the
// falling clock edge, matching the stage registers it controls.
// Optional feature: define PIPELINE_CONTROL_PERF_EN to add the stall,
// bubble and flush performance counters.
module pipeline_control (
    input  logic                clk,
    input  logic                rst_n,
    pipeline_control_if.slave   pc
`ifdef PIPELINE_CONTROL_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_bubbles,
    output logic [31:0]         perf_flushes
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;

    // Shadow pipeline: pending destination registers per stage
    logic       ex_vld_p0;
    logic [4:0] ex_rd_p0;
    logic       mem_vld_p1;
    logic [4:0] mem_rd_p1;
    logic       wb_vld_p2;
    logic [4:0] wb_rd_p2;

    logic       rs1_hit;
    logic       rs2_hit;
    logic       hazard;
    logic       issue;
    logic       stall_c;
    logic       stall_front_c;
    logic       bubble_c;
    logic       flush_c;
    logic       redirect_c;

    // Source registers matched against every valid pending write
    always_comb begin
        rs1_hit = (ex_vld_p0  && (ex_rd_p0  == pc.id_rs1_idx)) ||
                  (mem_vld_p1 && (mem_rd_p1 == pc.id_rs1_idx)) ||
                  (wb_vld_p2  && (wb_rd_p2  == pc.id_rs1_idx));
        rs2_hit = (ex_vld_p0  && (ex_rd_p0  == pc.id_rs2_idx)) ||
                  (mem_vld_p1 && (mem_rd_p1 == pc.id_rs2_idx)) ||
                  (wb_vld_p2  && (wb_rd_p2  == pc.id_rs2_idx));
        hazard  = pc.id_valid &&
                  ((pc.id_uses_rs1 && (pc.id_rs1_idx != 5'd0) && rs1_hit) ||
                   (pc.id_uses_rs2 && (pc.id_rs2_idx != 5'd0) && rs2_hit));
    end

    // Control decode: memory wait beats jump flush beats data hazard.
    // The ack cycle of a memory wait is evaluated like RUN so that a jump
    // held in the memory stage redirects as that stage finally advances.
    always_comb begin
        stall_c       = 1'b0;
        stall_front_c = 1'b0;
        bubble_c      = 1'b0;
        flush_c       = 1'b0;
        redirect_c    = 1'b0;
        state_d       = RUN;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (((state_q == MEM_WAIT) || pc.mem_access) && !pc.dmem_ack) begin
                    stall_c       = 1'b1;
                    stall_front_c = 1'b1;
                    state_d       = MEM_WAIT;
                end else if (pc.jump_taken) begin
                    flush_c       = 1'b1;
                    redirect_c    = 1'b1;
                    bubble_c      = 1'b1;
                    state_d       = REDIRECT;
                end else if (hazard) begin
                    stall_front_c = 1'b1;
                    bubble_c      = 1'b1;
                end
            end
            REDIRECT: begin
                flush_c = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!rst_n) begin
            stall_c       = 1'b0;
            stall_front_c = 1'b0;
            bubble_c      = 1'b0;
            flush_c       = 1'b0;
            redirect_c    = 1'b0;
        end
        issue = pc.id_valid && pc.id_reg_write && (pc.id_rd_idx != 5'd0) &&
                !hazard && !flush_c;
    end

    assign pc.stall       = stall_c;
    assign pc.stall_front = stall_front_c;
    assign pc.bubble_exec = bubble_c;
    assign pc.flush_front = flush_c;
    assign pc.pc_redirect = redirect_c;
    assign pc.state_out   = state_q;

    // State register and shadow pipeline advance; shadow frozen while stalled
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            ex_vld_p0  <= 1'b0;
            ex_rd_p0   <= 5'd0;
            mem_vld_p1 <= 1'b0;
            mem_rd_p1  <= 5'd0;
            wb_vld_p2  <= 1'b0;
            wb_rd_p2   <= 5'd0;
        end else begin
            state_q <= state_d;
            if (!stall_c) begin
                wb_vld_p2  <= mem_vld_p1;
                wb_rd_p2   <= mem_rd_p1;
                mem_vld_p1 <= ex_vld_p0;
                mem_rd_p1  <= ex_rd_p0;
                ex_vld_p0  <= issue;
                ex_rd_p0   <= pc.id_rd_idx;
            end
        end
    end

`ifdef PIPELINE_CONTROL_PERF_EN
    // Free-running event counters, wrapping modulo 2^32
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= 32'd0;
            perf_bubbles      <= 32'd0;
            perf_flushes      <= 32'd0;
        end else begin
            if (stall_c)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (bubble_c)
                perf_bubbles <= perf_bubbles + 32'd1;
            if ((state_d == REDIRECT) && (state_q != REDIRECT))
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule
